// File: rtl/mem_responder.sv
// mem_responder: register-array memory responder with fixed read latency,
// sticky protocol-error flags and saturating access counters.
module mem_responder #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  ready,
  output logic                  err_rw,
  output logic                  err_drop,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count
);
  typedef enum logic {IDLE, RD_WAIT} state_t;
  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);
  state_t                r_state, w_state_n;
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_fire_addr;
  logic [2:0]            r_lat_cnt;
  logic [CNT_WIDTH-1:0]  r_wr_cnt, r_rd_cnt;
  logic                  r_rd_valid, r_err_rw, r_err_drop;
  logic                  w_acc, w_wr, w_rd, w_rw, w_drop, w_done, w_fire;
  assign ready    = r_state == IDLE;
  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;
  assign err_rw   = r_err_rw;
  assign err_drop = r_err_drop;
  assign wr_count = r_wr_cnt;
  assign rd_count = r_rd_cnt;
  // With unit latency the read completes on its own sampling edge straight from addr.
  always_comb begin
    w_acc       = r_state == IDLE;
    w_wr        = w_acc & write & ~read;
    w_rd        = w_acc & read & ~write;
    w_rw        = w_acc & read & write;
    w_drop      = ~w_acc & (read | write);
    w_done      = r_state == RD_WAIT && r_lat_cnt == 3'd1;
    w_fire      = (READ_LATENCY == 1) ? w_rd : w_done;
    w_fire_addr = (READ_LATENCY == 1) ? addr : r_rd_addr;
    w_state_n   = w_done ? IDLE : (w_rd && READ_LATENCY > 1) ? RD_WAIT : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_lat_cnt  <= '0;
      r_err_rw   <= 1'b0;
      r_err_drop <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      for (int i = 0; i < 2**ADDR_WIDTH; i++) r_mem[i] <= '0;
    end else begin
      r_state    <= w_state_n;
      r_rd_valid <= w_fire;
      if (w_wr) r_mem[addr] <= data_in;
      if (w_fire) r_data_out <= r_mem[w_fire_addr];
      if (w_rd) r_rd_addr <= addr;
      if (w_rd) r_lat_cnt <= LAT_LOAD;
      else if (r_state == RD_WAIT) r_lat_cnt <= r_lat_cnt - 3'd1;
      if (w_rw) r_err_rw <= 1'b1;
      if (w_drop) r_err_drop <= 1'b1;
      if (w_wr && r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_fire && r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (latency 1/3/2, counter width 16/16/4) share one
// stimulus stream; each is checked every cycle against a cycle-numbered behavioural model.
module tb_mem_responder;
  logic clk = 1'b0, rst_n = 1'b1, read = 1'b0, write = 1'b0, en = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] din = '0;
  logic [2:0][7:0] dout;
  logic [2:0] rdv, rdy, erw, edr;
  logic [2:0][15:0] wc, rc;
  logic [3:0] wc4, rc4;
  int lat[3] = '{1, 3, 2};
  int cmax[3] = '{65535, 65535, 15};
  int nchk = 0, npass = 0, t = 0;
  logic [7:0] m_mem [3][32];
  logic [7:0] m_dout [3];
  logic [4:0] m_pa [3];
  bit m_rdv [3], m_pend [3], m_erw [3], m_edr [3];
  int m_wc [3], m_rc [3], m_end [3];
  always #5 clk = ~clk;
  assign wc[2] = {12'h0, wc4};
  assign rc[2] = {12'h0, rc4};
  mem_responder #(.READ_LATENCY(1)) d0 (.clk(clk), .rst_n(rst_n), .read(read), .write(write),
    .addr(addr), .data_in(din), .data_out(dout[0]), .rd_valid(rdv[0]), .ready(rdy[0]),
    .err_rw(erw[0]), .err_drop(edr[0]), .wr_count(wc[0]), .rd_count(rc[0]));
  mem_responder #(.READ_LATENCY(3)) d1 (.clk(clk), .rst_n(rst_n), .read(read), .write(write),
    .addr(addr), .data_in(din), .data_out(dout[1]), .rd_valid(rdv[1]), .ready(rdy[1]),
    .err_rw(erw[1]), .err_drop(edr[1]), .wr_count(wc[1]), .rd_count(rc[1]));
  mem_responder #(.READ_LATENCY(2), .CNT_WIDTH(4)) d2 (.clk(clk), .rst_n(rst_n), .read(read),
    .write(write), .addr(addr), .data_in(din), .data_out(dout[2]), .rd_valid(rdv[2]),
    .ready(rdy[2]), .err_rw(erw[2]), .err_drop(edr[2]), .wr_count(wc4), .rd_count(rc4));
  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
    else npass++;
  endtask
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 32; a++) m_mem[k][a] = '0;
      m_dout[k] = '0; m_pa[k] = '0; m_rdv[k] = 0; m_pend[k] = 0;
      m_erw[k] = 0; m_edr[k] = 0; m_wc[k] = 0; m_rc[k] = 0; m_end[k] = 0;
    end
  endtask
  // A read accepted at edge e delivers its data at edge e+lat-1; the responder is busy until then.
  task automatic model_step();
    t++;
    for (int k = 0; k < 3; k++) begin
      m_rdv[k] = 0;
      if (m_pend[k]) begin
        if (read || write) m_edr[k] = 1;
        if (t == m_end[k]) begin
          m_dout[k] = m_mem[k][m_pa[k]]; m_rdv[k] = 1; m_pend[k] = 0;
          if (m_rc[k] < cmax[k]) m_rc[k]++;
        end
      end else if (read && write) m_erw[k] = 1;
      else if (write) begin
        m_mem[k][addr] = din;
        if (m_wc[k] < cmax[k]) m_wc[k]++;
      end else if (read) begin
        if (lat[k] == 1) begin
          m_dout[k] = m_mem[k][addr]; m_rdv[k] = 1;
          if (m_rc[k] < cmax[k]) m_rc[k]++;
        end else begin
          m_pend[k] = 1; m_end[k] = t + lat[k] - 1; m_pa[k] = addr;
        end
      end
    end
  endtask
  always @(negedge clk) if (en) for (int k = 0; k < 3; k++) begin
    chk("data_out", k, 32'(dout[k]), 32'(m_dout[k]));
    chk("rd_valid", k, 32'(rdv[k]), 32'(m_rdv[k]));
    chk("ready", k, 32'(rdy[k]), 32'(!m_pend[k]));
    chk("err_rw", k, 32'(erw[k]), 32'(m_erw[k]));
    chk("err_drop", k, 32'(edr[k]), 32'(m_edr[k]));
    chk("wr_count", k, 32'(wc[k]), 32'(m_wc[k]));
    chk("rd_count", k, 32'(rc[k]), 32'(m_rc[k]));
  end
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask
  task automatic do_wr(input int a, input int d);
    write = 1'b1; addr = 5'(a); din = 8'(d);
    tick();
    write = 1'b0;
  endtask
  task automatic do_rd(input int a);
    read = 1'b1; addr = 5'(a);
    tick();
    read = 1'b0;
    repeat (3) tick();
  endtask
  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 0, 32'(rdy[0]), 1);
    chk("rst_dout", 1, 32'(dout[1]), 0);
    chk("rst_wc", 2, 32'(wc[2]), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) do_wr(i, 0);
    for (int i = 0; i < 32; i++) do_rd(i);
    chk("clear_rc", 0, 32'(rc[0]), 32);
    chk("clear_wc", 1, 32'(wc[1]), 32);
    chk("clear_wc_sat", 2, 32'(wc[2]), 15);
    for (int i = 0; i < 32; i++) do_wr(i, i);
    for (int i = 0; i < 32; i++) do_rd(i);
    chk("dataaddr_dout", 0, 32'(dout[0]), 31);
    chk("dataaddr_dout", 1, 32'(dout[1]), 31);
    read = 1'b1; write = 1'b1; addr = 5'd5; din = 8'hAA;
    tick();
    read = 1'b0; write = 1'b0;
    tick();
    chk("coll_err_rw", 0, 32'(erw[0]), 1);
    chk("coll_wc", 0, 32'(wc[0]), 64);
    chk("coll_rc", 1, 32'(rc[1]), 64);
    do_rd(5);
    chk("coll_mem5", 0, 32'(dout[0]), 5);
    do_wr(7, 8'h3C);
    read = 1'b1; addr = 5'd7;
    tick();
    read = 1'b0; write = 1'b1; addr = 5'd9; din = 8'h55;
    @(negedge clk); chk("lat3_busy1", 1, 32'(rdy[1]), 0);
    tick();
    write = 1'b0;
    @(negedge clk); chk("lat3_busy2", 1, 32'(rdy[1]), 0);
    tick();
    @(negedge clk);
    chk("lat3_valid", 1, 32'(rdv[1]), 1);
    chk("lat3_dout", 1, 32'(dout[1]), 32'h3C);
    chk("lat3_ready", 1, 32'(rdy[1]), 1);
    chk("lat3_drop", 1, 32'(edr[1]), 1);
    chk("lat3_wc", 1, 32'(wc[1]), 65);
    chk("lat1_wc", 0, 32'(wc[0]), 66);
    repeat (2) tick();
    read = 1'b1; addr = 5'd7;
    tick();
    read = 1'b0;
    tick();
    rst_n = 1'b0; model_reset();
    @(negedge clk);
    chk("midrst_ready", 1, 32'(rdy[1]), 1);
    chk("midrst_dout", 1, 32'(dout[1]), 0);
    chk("midrst_rc", 1, 32'(rc[1]), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("midrst_novalid", 1, 32'(rdv[1]), 0);
    do_rd(7);
    chk("midrst_mem7", 1, 32'(dout[1]), 0);
    chk("midrst_rc_after", 1, 32'(rc[1]), 1);
    for (int i = 0; i < 4; i++) do_wr(i, 8'h80 + i);
    read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 5'(i);
      tick();
    end
    read = 1'b0;
    repeat (3) tick();
    chk("burst_dout", 0, 32'(dout[0]), 32'h83);
    chk("burst_rc", 0, 32'(rc[0]), 5);
    for (int i = 0; i < 20; i++) do_wr(i, i);
    repeat (2) tick();
    chk("sat_wc", 2, 32'(wc[2]), 15);
    chk("nosat_wc", 0, 32'(wc[0]), 24);
    @(negedge clk);
    en = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
